// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_pkg
//  Description : Shared types and constants for the SLC-3 register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3_pkg;

    typedef logic [2:0] nzp_t;

    localparam nzp_t NZP_N     = 3'b100;
    localparam nzp_t NZP_Z     = 3'b010;
    localparam nzp_t NZP_P     = 3'b001;
    localparam nzp_t NZP_RESET = NZP_Z;

    // Condition code for a value, LC-3 rules: negative, zero, else positive.
    function automatic nzp_t nzp_encode(input logic sign, input logic is_zero);
        nzp_t code;
        code = NZP_P;
        if (sign) begin
            code = NZP_N;
        end else if (is_zero) begin
            code = NZP_Z;
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_reg_file_reg_cell.sv
`default_nettype none
// ============================================================================
//  Module      : reg_cell
//  Description : Single loadable register; synchronous reset > load > hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_cell #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else if (load) begin
            r_q <= din;
        end
    end

    assign dout = r_q;

endmodule
`default_nettype wire

// File: rtl/lc3_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_reg_file
//  Description : SLC-3 register file: 2 async reads, 1 sync write, optional
//                write->read bypass, busy scoreboard and NZP condition code.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_reg_file
    import lc3_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 8,
    parameter  int BYPASS = 1,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              cc_load,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    output logic [2:0]        nzp
);

    logic [DEPTH-1:0][WIDTH-1:0] w_regs;
    logic [DEPTH-1:0]            r_busy;

    logic [WIDTH-1:0] w_arr_a;
    logic [WIDTH-1:0] w_arr_b;
    logic             w_busy_arr_a;
    logic             w_busy_arr_b;
    logic             w_valid_a;
    logic             w_valid_b;
    logic             w_fwd_a;
    logic             w_fwd_b;
    nzp_t             w_nzp_next;

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        logic w_load;
        assign w_load = wr_en && (wr_addr == ADDR_W'(gi));

        reg_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL ('0)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (w_load),
            .din   (wr_data),
            .dout  (w_regs[gi])
        );
    end

    // ------------------------------------------------------------------
    // Busy scoreboard: a new issue outranks a clearing writeback
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_en && (issue_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read muxes; an address with no matching register reads as 0 / idle
    // ------------------------------------------------------------------
    always_comb begin
        w_arr_a      = '0;
        w_arr_b      = '0;
        w_busy_arr_a = 1'b0;
        w_busy_arr_b = 1'b0;
        w_valid_a    = 1'b0;
        w_valid_b    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                w_arr_a      = w_regs[i];
                w_busy_arr_a = r_busy[i];
                w_valid_a    = 1'b1;
            end
            if (rd_addr_b == ADDR_W'(i)) begin
                w_arr_b      = w_regs[i];
                w_busy_arr_b = r_busy[i];
                w_valid_b    = 1'b1;
            end
        end
    end

    if (BYPASS != 0) begin : g_bypass
        assign w_fwd_a = wr_en && (wr_addr == rd_addr_a) && w_valid_a;
        assign w_fwd_b = wr_en && (wr_addr == rd_addr_b) && w_valid_b;
    end else begin : g_no_bypass
        assign w_fwd_a = 1'b0;
        assign w_fwd_b = 1'b0;
    end

    assign rd_data_a = w_fwd_a ? wr_data : w_arr_a;
    assign rd_data_b = w_fwd_b ? wr_data : w_arr_b;
    assign rd_busy_a = w_busy_arr_a && !w_fwd_a;
    assign rd_busy_b = w_busy_arr_b && !w_fwd_b;

    // ------------------------------------------------------------------
    // Condition code; updates even when the write address is out of range
    // ------------------------------------------------------------------
    assign w_nzp_next = nzp_encode(wr_data[WIDTH-1], (wr_data == '0));

    reg_cell #(
        .WIDTH     (3),
        .RESET_VAL (NZP_RESET)
    ) u_nzp (
        .clk   (clk),
        .reset (reset),
        .load  (wr_en && cc_load),
        .din   (w_nzp_next),
        .dout  (nzp)
    );

endmodule
`default_nettype wire
